// File: rtl/slip_tx_pattern_gen_pkg.sv
// Link-level constants and state encoding shared by the transmit pattern
// generator and the receive-side slip detector.
package slip_tx_pattern_gen_pkg;

  localparam int WORD_W = 10;

  localparam logic [WORD_W-1:0] TRAIN_WORD = 10'h01F;
  localparam logic [WORD_W-1:0] IDLE_WORD  = 10'h155;

  typedef enum logic {
    TRAIN = 1'b0,
    DATA  = 1'b1
  } link_state_e;

endpackage : slip_tx_pattern_gen_pkg

// File: rtl/slip_tx_pattern_gen_if.sv
// Upstream payload valid/ready channel feeding the transmit pattern generator.
interface slip_tx_pattern_gen_if;
  import slip_tx_pattern_gen_pkg::*;

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface : slip_tx_pattern_gen_if

// File: rtl/slip_tx_pattern_gen.sv
// Transmit word source: training words until the far end can align, then
// payload from upstream with idle fill; retrains on request from link control.
module slip_tx_pattern_gen
  import slip_tx_pattern_gen_pkg::*;
#(
  parameter int unsigned MIN_TRAIN = 128
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  train_req,
  slip_tx_pattern_gen_if.slave  s,
  output logic [WORD_W-1:0]     tx_data,
  output logic                  training,
  output logic                  train_done,
  output logic [15:0]           word_cnt
);

  localparam logic [15:0] MIN_TRAIN_W  = 16'(MIN_TRAIN);
  localparam logic [15:0] MIN_TRAIN_M1 = 16'(MIN_TRAIN - 1);

  link_state_e       state_q, state_d;
  logic [15:0]       train_cnt_q, train_cnt_d;
  logic [WORD_W-1:0] tx_q, tx_d;
  logic              training_q, training_d;
  logic              done_q, done_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic              accept;

  // Ready is driven from registered state so a retrain request blocks the
  // handshake in the very cycle it rises.
  assign s.s_ready = (state_q == DATA) && !train_req;
  assign accept    = s.s_valid && s.s_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and infers a latch.
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    tx_d        = IDLE_WORD;
    training_d  = 1'b0;
    done_d      = 1'b0;
    word_cnt_d  = word_cnt_q;

    case (state_q)
      TRAIN: begin
        tx_d       = TRAIN_WORD;
        training_d = 1'b1;
        if (train_cnt_q < MIN_TRAIN_W) train_cnt_d = train_cnt_q + 16'd1;
        // Leaving on this edge means tx_data already carried MIN_TRAIN
        // training words; the first DATA word is idle since nothing was accepted.
        if (train_cnt_q >= MIN_TRAIN_M1 && !train_req) begin
          state_d    = DATA;
          tx_d       = IDLE_WORD;
          training_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      DATA: begin
        if (train_req) begin
          state_d     = TRAIN;
          tx_d        = TRAIN_WORD;
          training_d  = 1'b1;
          train_cnt_d = '0;
          word_cnt_d  = '0;
        end else if (accept) begin
          tx_d       = s.s_data;
          word_cnt_d = word_cnt_q + 16'd1;
        end
      end
      default: state_d = TRAIN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= TRAIN;
      train_cnt_q <= '0;
      tx_q        <= TRAIN_WORD;
      training_q  <= 1'b1;
      done_q      <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      tx_q        <= tx_d;
      training_q  <= training_d;
      done_q      <= done_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign tx_data    = tx_q;
  assign training   = training_q;
  assign train_done = done_q;
  assign word_cnt   = word_cnt_q;

endmodule : slip_tx_pattern_gen

// File: tb/tb_slip_tx_pattern_gen.sv
// Scoreboard bench: the driver predicts each registered output from a
// word-level link model; a monitor pops and compares after every clock edge.
module tb_slip_tx_pattern_gen;
  import slip_tx_pattern_gen_pkg::*;

  localparam int MIN_TRAIN = 128;

  typedef struct {
    logic [WORD_W-1:0] tx;
    logic              training;
    logic              done;
    logic [15:0]       cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              resetn;
  logic              train_req;
  logic [WORD_W-1:0] tx_data;
  logic              training;
  logic              train_done;
  logic [15:0]       word_cnt;

  slip_tx_pattern_gen_if bus ();

  slip_tx_pattern_gen #(.MIN_TRAIN(MIN_TRAIN)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .train_req (train_req),
    .s         (bus.slave),
    .tx_data   (tx_data),
    .training  (training),
    .train_done(train_done),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  // Link model: whether payload is flowing, how many training words have
  // been on the wire this period (current one included), payload count.
  bit m_in_data;
  int m_train_words;
  int m_cnt;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] rand_word();
    logic [WORD_W-1:0] w;
    w = WORD_W'($urandom);
    while (w == TRAIN_WORD) w = WORD_W'($urandom);
    return w;
  endfunction

  task automatic model_reset();
    m_in_data     = 1'b0;
    m_train_words = 1;
    m_cnt         = 0;
  endtask

  // Called just after a falling edge: drive inputs, check ready, predict the
  // outputs that the next rising edge must produce.
  task automatic step(input bit req, input bit valid, input logic [WORD_W-1:0] data,
                      output bit accepted);
    exp_t e;
    train_req   = req;
    bus.s_valid = valid;
    bus.s_data  = data;
    #1;
    check("s_ready", 32'(bus.s_ready), 32'(m_in_data && !req));
    accepted = m_in_data && !req && valid;
    if (!m_in_data) begin
      if (m_train_words >= MIN_TRAIN && !req) begin
        m_in_data = 1'b1;
        e = '{IDLE_WORD, 1'b1 ^ 1'b1, 1'b1, 16'(m_cnt)};
      end else begin
        if (m_train_words < MIN_TRAIN) m_train_words++;
        e = '{TRAIN_WORD, 1'b1, 1'b0, 16'(m_cnt)};
      end
    end else if (req) begin
      m_in_data     = 1'b0;
      m_train_words = 1;
      m_cnt         = 0;
      e = '{TRAIN_WORD, 1'b1, 1'b0, 16'h0};
    end else if (valid) begin
      m_cnt = (m_cnt + 1) % 65536;
      e = '{data, 1'b0, 1'b0, 16'(m_cnt)};
    end else begin
      e = '{IDLE_WORD, 1'b0, 1'b0, 16'(m_cnt)};
    end
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_tx"},       32'(tx_data),     32'(TRAIN_WORD));
    check({tag, "_training"}, 32'(training),    32'd1);
    check({tag, "_s_ready"},  32'(bus.s_ready), 32'd0);
    check({tag, "_done"},     32'(train_done),  32'd0);
    check({tag, "_word_cnt"}, 32'(word_cnt),    32'd0);
  endtask

  // Asynchronous reset in the middle of a cycle, held for `hold` more cycles,
  // released on a falling edge.
  task automatic reset_pulse(input int hold);
    exp_t e;
    bit   acc;
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    e = '{TRAIN_WORD, 1'b1, 1'b0, 16'h0};
    exp_q.push_back(e);
    repeat (hold) begin
      @(negedge clk);
      exp_q.push_back(e);
    end
    @(negedge clk);
    resetn = 1'b1;
    step(1'b0, 1'b0, '0, acc);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tx_data",    32'(tx_data),    32'(e.tx));
        check("training",   32'(training),   32'(e.training));
        check("train_done", 32'(train_done), 32'(e.done));
        check("word_cnt",   32'(word_cnt),   32'(e.cnt));
      end
    end
  end

  initial begin : driver
    bit                acc;
    bit                have_word;
    logic [WORD_W-1:0] word;
    int                total;

    resetn      = 1'b0;
    train_req   = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 10'h2AA;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    resetn = 1'b1;
    step(1'b0, 1'b0, '0, acc);

    // Plain training period then idle fill.
    repeat (MIN_TRAIN + 40) begin
      @(negedge clk);
      step(1'b0, 1'b0, '0, acc);
    end

    // Training held by request well past the minimum.
    reset_pulse(2);
    repeat (300) begin
      @(negedge clk);
      step(1'b1, 1'b1, 10'h3C0, acc);
    end
    repeat (5) begin
      @(negedge clk);
      step(1'b0, 1'b0, '0, acc);
    end

    // Back-to-back payload words.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      step(1'b0, 1'b1, WORD_W'(i), acc);
    end
    repeat (3) begin
      @(negedge clk);
      step(1'b0, 1'b0, '0, acc);
    end

    // One-cycle retrain pulse during a stream.
    repeat (6) begin
      @(negedge clk);
      step(1'b0, 1'b1, rand_word(), acc);
    end
    @(negedge clk);
    step(1'b1, 1'b1, 10'h0AB, acc);
    repeat (MIN_TRAIN + 10) begin
      @(negedge clk);
      step(1'b0, 1'b1, 10'h0AB, acc);
    end

    // Request falls exactly on the edge where the minimum is reached.
    @(negedge clk);
    step(1'b1, 1'b1, 10'h111, acc);
    repeat (MIN_TRAIN - 1) begin
      @(negedge clk);
      step(1'b1, 1'b1, 10'h111, acc);
    end
    repeat (4) begin
      @(negedge clk);
      step(1'b0, 1'b1, 10'h111, acc);
    end

    // Reset in the middle of payload word 0x2C3.
    @(negedge clk);
    step(1'b0, 1'b1, 10'h2C3, acc);
    reset_pulse(3);
    repeat (MIN_TRAIN + 10) begin
      @(negedge clk);
      step(1'b0, 1'b1, 10'h2C3, acc);
    end

    // Randomised source that holds each word until accepted.
    have_word = 1'b0;
    word      = '0;
    repeat (3000) begin
      @(negedge clk);
      if (!have_word && $urandom_range(0, 3) != 0) begin
        have_word = 1'b1;
        word      = rand_word();
      end
      step($urandom_range(0, 99) < 2, have_word, word, acc);
      if (acc) have_word = 1'b0;
    end

    // Counter wrap after 65536 accepted words.
    reset_pulse(1);
    total = 0;
    for (int cyc = 0; cyc < 70000 && total < 65536; cyc++) begin
      @(negedge clk);
      step(1'b0, 1'b1, rand_word(), acc);
      if (acc) total++;
    end
    check("wrap_accepts", 32'(total), 32'd65536);
    @(posedge clk);
    #2;
    check("wrap_word_cnt", 32'(word_cnt), 32'd0);
    repeat (3) begin
      @(negedge clk);
      step(1'b0, 1'b1, rand_word(), acc);
    end

    @(negedge clk);
    train_req   = 1'b0;
    bus.s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_slip_tx_pattern_gen
